reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_if.sv | 27 ++
 rtl/reg_bank.sv | 59 +++++
 tb/tb_reg_bank.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: one write port, two combinational read ports and occupancy.
interface reg_bank_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              load;
    logic [ADDR_W-1:0] addr_w;
    logic [WIDTH-1:0]  data_in;
    logic              clear;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  q_a;
    logic [WIDTH-1:0]  q_b;
    logic              valid_a;
    logic              valid_b;
    logic [ADDR_W:0]   valid_count;

    modport master (
        output load, addr_w, data_in, clear, addr_a, addr_b,
        input  q_a, q_b, valid_a, valid_b, valid_count
    );

    modport slave (
        input  load, addr_w, data_in, clear, addr_a, addr_b,
        output q_a, q_b, valid_a, valid_b, valid_count
    );
endinterface

// File: rtl/reg_bank.sv
// Register bank with per-entry valid flags, occupancy counter and optional write forwarding.
module reg_bank #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 0
) (
    input logic       clk,
    input logic       reset,
    reg_bank_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [ADDR_W:0]  count;
    logic             fwd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
            count <= '0;
        end else if (bus.clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
            count <= '0;
        end else if (bus.load) begin
            mem[bus.addr_w]   <= bus.data_in;
            valid[bus.addr_w] <= 1'b1;
            // Only a first write to an entry adds to the occupancy
            if (!valid[bus.addr_w]) count <= count + 1'b1;
        end
    end

    assign fwd = (BYPASS != 0) && bus.load && !bus.clear && !reset;

    always_comb begin
        bus.q_a     = mem[bus.addr_a];
        bus.valid_a = valid[bus.addr_a];
        bus.q_b     = mem[bus.addr_b];
        bus.valid_b = valid[bus.addr_b];
        if (fwd && bus.addr_a == bus.addr_w) begin
            bus.q_a     = bus.data_in;
            bus.valid_a = 1'b1;
        end
        if (fwd && bus.addr_b == bus.addr_w) begin
            bus.q_b     = bus.data_in;
            bus.valid_b = 1'b1;
        end
        if (reset) begin
            bus.q_a     = '0;
            bus.valid_a = 1'b0;
            bus.q_b     = '0;
            bus.valid_b = 1'b0;
        end
    end

    assign bus.valid_count = count;
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench: both BYPASS variants driven in parallel against an array-based model.
module tb_reg_bank;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              load, clear;
    logic [ADDR_W-1:0] addr_w, addr_a, addr_b;
    logic [WIDTH-1:0]  data_in;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] mem_m [DEPTH];
    bit               vld_m [DEPTH];

    reg_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus0 ();
    reg_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus1 ();

    assign bus0.load = load;   assign bus1.load = load;
    assign bus0.clear = clear; assign bus1.clear = clear;
    assign bus0.addr_w = addr_w; assign bus1.addr_w = addr_w;
    assign bus0.data_in = data_in; assign bus1.data_in = data_in;
    assign bus0.addr_a = addr_a; assign bus1.addr_a = addr_a;
    assign bus0.addr_b = addr_b; assign bus1.addr_b = addr_b;

    reg_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    reg_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            vld_m[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (reset) return;
        if (clear) model_clear();
        else if (load) begin
            mem_m[addr_w] = data_in;
            vld_m[addr_w] = 1'b1;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(vld_m[i]);
        return n;
    endfunction

    // {valid, data} a read port is expected to show right now
    function automatic logic [WIDTH:0] exp_port(input bit byp, input logic [ADDR_W-1:0] a);
        if (reset) return '0;
        if (byp && load && !clear && a == addr_w) return {1'b1, data_in};
        return {vld_m[a], mem_m[a]};
    endfunction

    task automatic check_all(input string tag);
        logic [WIDTH:0] ea0, eb0, ea1, eb1;
        ea0 = exp_port(1'b0, addr_a); eb0 = exp_port(1'b0, addr_b);
        ea1 = exp_port(1'b1, addr_a); eb1 = exp_port(1'b1, addr_b);
        check({tag, " nb q_a"}, 32'(bus0.q_a), 32'(ea0[WIDTH-1:0]));
        check({tag, " nb valid_a"}, 32'(bus0.valid_a), 32'(ea0[WIDTH]));
        check({tag, " nb q_b"}, 32'(bus0.q_b), 32'(eb0[WIDTH-1:0]));
        check({tag, " nb valid_b"}, 32'(bus0.valid_b), 32'(eb0[WIDTH]));
        check({tag, " nb count"}, 32'(bus0.valid_count), 32'(model_count()));
        check({tag, " by q_a"}, 32'(bus1.q_a), 32'(ea1[WIDTH-1:0]));
        check({tag, " by valid_a"}, 32'(bus1.valid_a), 32'(ea1[WIDTH]));
        check({tag, " by q_b"}, 32'(bus1.q_b), 32'(eb1[WIDTH-1:0]));
        check({tag, " by valid_b"}, 32'(bus1.valid_b), 32'(eb1[WIDTH]));
        check({tag, " by count"}, 32'(bus1.valid_count), 32'(model_count()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic              load;
        logic              clear;
        logic [ADDR_W-1:0] aw;
        logic [WIDTH-1:0]  din;
        logic [ADDR_W-1:0] aa;
        logic [ADDR_W-1:0] ab;
        logic [WIDTH-1:0]  qa;
        logic              va;
        logic [WIDTH-1:0]  qb;
        logic              vb;
        logic [ADDR_W:0]   cnt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 3'd2, 16'hAAAA, 3'd2, 3'd3, 16'hAAAA, 1'b1, 16'h0000, 1'b0, 4'd1};
        vecs[1] = '{1'b1, 1'b0, 3'd5, 16'h1234, 3'd5, 3'd2, 16'h1234, 1'b1, 16'hAAAA, 1'b1, 4'd2};
        vecs[2] = '{1'b1, 1'b0, 3'd5, 16'h5678, 3'd5, 3'd5, 16'h5678, 1'b1, 16'h5678, 1'b1, 4'd2};
        vecs[3] = '{1'b1, 1'b1, 3'd1, 16'hBEEF, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0};
        vecs[4] = '{1'b0, 1'b0, 3'd1, 16'h0000, 3'd1, 3'd5, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0};

        reset = 1'b1; load = 1'b0; clear = 1'b0;
        addr_w = '0; addr_a = '0; addr_b = '0; data_in = '0;
        model_clear();
        #3;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed table, checked on the non-bypass bank after each edge
        foreach (vecs[i]) begin
            load = vecs[i].load; clear = vecs[i].clear; addr_w = vecs[i].aw;
            data_in = vecs[i].din; addr_a = vecs[i].aa; addr_b = vecs[i].ab;
            tick();
            check($sformatf("vec%0d q_a", i), 32'(bus0.q_a), 32'(vecs[i].qa));
            check($sformatf("vec%0d valid_a", i), 32'(bus0.valid_a), 32'(vecs[i].va));
            check($sformatf("vec%0d q_b", i), 32'(bus0.q_b), 32'(vecs[i].qb));
            check($sformatf("vec%0d valid_b", i), 32'(bus0.valid_b), 32'(vecs[i].vb));
            check($sformatf("vec%0d count", i), 32'(bus0.valid_count), 32'(vecs[i].cnt));
        end

        // Fill every address, then read back on both ports
        for (int i = 0; i < DEPTH; i++) begin
            load = 1'b1; clear = 1'b0; addr_w = ADDR_W'(i); data_in = 16'h0100 + 16'(i);
            tick();
        end
        load = 1'b0;
        check("fill count", 32'(bus0.valid_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            addr_a = ADDR_W'(i); addr_b = ADDR_W'(DEPTH - 1 - i);
            #1;
            check($sformatf("fill a%0d", i), 32'(bus1.q_a), 32'h0100 + 32'(i));
            check($sformatf("fill b%0d", DEPTH - 1 - i), 32'(bus0.q_b), 32'h0100 + 32'(DEPTH - 1 - i));
        end

        // Forwarding vs one-cycle latency on a rewrite of reg 4
        do_reset();
        load = 1'b1; addr_w = 3'd4; data_in = 16'h1111; tick();
        data_in = 16'h2222; addr_a = 3'd4; addr_b = 3'd0;
        #1;
        check("fwd by pre", 32'(bus1.q_a), 32'h2222);
        check("fwd nb pre", 32'(bus0.q_a), 32'h1111);
        check_all("fwd pre");
        tick();
        load = 1'b0;
        #1;
        check("fwd nb post", 32'(bus0.q_a), 32'h2222);

        // Clear with load: stored contents shown before the edge, zeros after
        load = 1'b1; clear = 1'b1; addr_w = 3'd4; data_in = 16'h3333;
        #1;
        check("clr by pre", 32'(bus1.q_a), 32'h2222);
        check_all("clr pre");
        tick();
        load = 1'b0; clear = 1'b0;
        #1;
        check_all("clr post");

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; addr_w = ADDR_W'(i + 1); data_in = 16'hC000 + 16'(i); tick();
        end
        load = 1'b0; addr_a = 3'd2; addr_b = 3'd3;
        @(negedge clk);
        #2;
        check("pre-async count", 32'(bus0.valid_count), 32'd3);
        reset = 1'b1;
        model_clear();
        #1;
        check("async q_a", 32'(bus0.q_a), 32'h0);
        check("async count", 32'(bus1.valid_count), 32'd0);
        load = 1'b1; addr_w = 3'd2; data_in = 16'h7777;
        #1;
        check("reset no fwd", 32'(bus1.q_a), 32'h0);
        check_all("in reset");
        reset = 1'b0; addr_w = 3'd6; data_in = 16'h6666; addr_a = 3'd6;
        tick();
        load = 1'b0;
        #1;
        check("post-reset write", 32'(bus0.q_a), 32'h6666);
        check("post-reset count", 32'(bus0.valid_count), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            load    = ($urandom_range(0, 3) != 0);
            clear   = ($urandom_range(0, 39) == 0);
            addr_w  = ADDR_W'($urandom);
            addr_a  = ($urandom_range(0, 2) == 0) ? addr_w : ADDR_W'($urandom);
            addr_b  = ($urandom_range(0, 3) == 0) ? addr_a : ADDR_W'($urandom);
            data_in = WIDTH'($urandom);
            @(negedge clk);
            check_all("rand");
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
